alu_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU and produces its A, B and ALUOP inputs.
- Latches decoded instructions and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts a bubble while stalling decode.
- Also supplies the forwarded rt value to the memory stage as store data.

---
 rtl/alu_operand_stage_if.sv | 55 +++++
 rtl/alu_operand_stage.sv | 111 +++++++++++
 tb/tb_alu_operand_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// ID/EX operand-stage bus: decode fields, bypass ports and ALU-facing outputs.
// The master side drives the decode/bypass inputs and observes the results; the stage is the slave.
interface alu_operand_stage_if #(
    parameter int unsigned SIZE = 32,
    parameter int unsigned REGW = 5
);
    logic            ex_en;
    logic            flush;
    logic            id_valid;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_uses_rs;
    logic            id_uses_rt;
    logic [SIZE-1:0] id_rdata1;
    logic [SIZE-1:0] id_rdata2;
    logic [SIZE-1:0] id_imm;
    logic            id_use_imm;
    logic            id_is_shift;
    logic [4:0]      id_shamt;
    logic [3:0]      id_aluop;
    logic [REGW-1:0] id_dest;
    logic            id_wen;
    logic            id_is_load;
    logic            exmem_wen;
    logic [REGW-1:0] exmem_dest;
    logic [SIZE-1:0] exmem_result;
    logic            memwb_wen;
    logic [REGW-1:0] memwb_dest;
    logic [SIZE-1:0] memwb_data;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [3:0]      aluop;
    logic [SIZE-1:0] store_data;
    logic [REGW-1:0] dest;
    logic            wen_out;
    logic            is_load_out;
    logic            valid_out;
    logic            stall;

    modport master (
        output ex_en, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rdata1, id_rdata2, id_imm, id_use_imm, id_is_shift, id_shamt,
               id_aluop, id_dest, id_wen, id_is_load,
               exmem_wen, exmem_dest, exmem_result, memwb_wen, memwb_dest, memwb_data,
        input  a, b, aluop, store_data, dest, wen_out, is_load_out, valid_out, stall
    );

    modport slave (
        input  ex_en, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rdata1, id_rdata2, id_imm, id_use_imm, id_is_shift, id_shamt,
               id_aluop, id_dest, id_wen, id_is_load,
               exmem_wen, exmem_dest, exmem_result, memwb_wen, memwb_dest, memwb_data,
        output a, b, aluop, store_data, dest, wen_out, is_load_out, valid_out, stall
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding, operand select
// and load-use bubble insertion, feeding the ALU and the store-data path.
module alu_operand_stage #(
    parameter int unsigned SIZE = 32,
    parameter int unsigned REGW = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_operand_stage_if.slave bus
);
    logic            valid_q;
    logic [REGW-1:0] rs_q;
    logic [REGW-1:0] rt_q;
    logic [SIZE-1:0] rdata1_q;
    logic [SIZE-1:0] rdata2_q;
    logic [SIZE-1:0] imm_q;
    logic            use_imm_q;
    logic            is_shift_q;
    logic [4:0]      shamt_q;
    logic [3:0]      aluop_q;
    logic [REGW-1:0] dest_q;
    logic            wen_q;
    logic            is_load_q;

    logic [SIZE-1:0] fwd_rs;
    logic [SIZE-1:0] fwd_rt;
    logic            stall_c;

    // Bypass mux on the registered sources; EX/MEM wins, $0 is never forwarded.
    always_comb begin
        fwd_rs = rdata1_q;
        if (bus.exmem_wen && bus.exmem_dest == rs_q && rs_q != '0)
            fwd_rs = bus.exmem_result;
        else if (bus.memwb_wen && bus.memwb_dest == rs_q && rs_q != '0)
            fwd_rs = bus.memwb_data;

        fwd_rt = rdata2_q;
        if (bus.exmem_wen && bus.exmem_dest == rt_q && rt_q != '0)
            fwd_rt = bus.exmem_result;
        else if (bus.memwb_wen && bus.memwb_dest == rt_q && rt_q != '0)
            fwd_rt = bus.memwb_data;
    end

    // A load in EX whose result decode needs next cycle cannot be forwarded in time.
    always_comb begin
        stall_c = valid_q && is_load_q && (dest_q != '0) && bus.id_valid &&
                  ((bus.id_uses_rs && bus.id_rs == dest_q) ||
                   (bus.id_uses_rt && bus.id_rt == dest_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            is_shift_q <= 1'b0;
            shamt_q    <= '0;
            aluop_q    <= '0;
            dest_q     <= '0;
            wen_q      <= 1'b0;
            is_load_q  <= 1'b0;
        end else if (!bus.ex_en) begin
            // Keep forwarded values so they survive their producer retiring during the hold.
            rdata1_q <= fwd_rs;
            rdata2_q <= fwd_rt;
        end else if (bus.flush || stall_c) begin
            valid_q   <= 1'b0;
            wen_q     <= 1'b0;
            is_load_q <= 1'b0;
            dest_q    <= '0;
            aluop_q   <= '0;
        end else begin
            valid_q    <= bus.id_valid;
            rs_q       <= bus.id_rs;
            rt_q       <= bus.id_rt;
            rdata1_q   <= bus.id_rdata1;
            rdata2_q   <= bus.id_rdata2;
            imm_q      <= bus.id_imm;
            use_imm_q  <= bus.id_use_imm;
            is_shift_q <= bus.id_is_shift;
            shamt_q    <= bus.id_shamt;
            aluop_q    <= bus.id_aluop;
            dest_q     <= bus.id_dest;
            wen_q      <= bus.id_wen;
            is_load_q  <= bus.id_is_load;
        end
    end

    always_comb begin
        bus.a = fwd_rs;
        bus.b = fwd_rt;
        if (is_shift_q) begin
            bus.a = fwd_rt;
            bus.b = SIZE'(shamt_q);
        end else if (use_imm_q) begin
            bus.b = imm_q;
        end
    end

    assign bus.store_data  = fwd_rt;
    assign bus.aluop       = aluop_q;
    assign bus.dest        = dest_q;
    assign bus.wen_out     = wen_q & valid_q;
    assign bus.is_load_out = is_load_q;
    assign bus.valid_out   = valid_q;
    assign bus.stall       = stall_c;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, forwarding priority, operand select,
// load-use stall, hold capture and flush, with hand-computed expectations.
module tb_alu_operand_stage;
    localparam int unsigned SIZE = 32;
    localparam int unsigned REGW = 5;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    alu_operand_stage_if #(.SIZE(SIZE), .REGW(REGW)) bus ();

    alu_operand_stage #(.SIZE(SIZE), .REGW(REGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rd1, input logic [31:0] rd2, input logic [3:0] op,
                          input logic [4:0] dst, input logic wen, input logic ld);
        bus.id_valid    = valid;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rdata1   = rd1;
        bus.id_rdata2   = rd2;
        bus.id_aluop    = op;
        bus.id_dest     = dst;
        bus.id_wen      = wen;
        bus.id_is_load  = ld;
        bus.id_uses_rs  = 1'b0;
        bus.id_uses_rt  = 1'b0;
        bus.id_use_imm  = 1'b0;
        bus.id_is_shift = 1'b0;
        bus.id_imm      = '0;
        bus.id_shamt    = '0;
    endtask

    task automatic clear_bypass();
        bus.exmem_wen    = 1'b0;
        bus.exmem_dest   = '0;
        bus.exmem_result = '0;
        bus.memwb_wen    = 1'b0;
        bus.memwb_dest   = '0;
        bus.memwb_data   = '0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.ex_en = 1'b1;
        bus.flush = 1'b0;
        clear_bypass();
        set_id(1'b1, 5'($urandom), 5'($urandom), $urandom, $urandom, 4'($urandom),
               5'($urandom), 1'b1, 1'b1);
        bus.id_uses_rs = 1'b1;
        bus.id_uses_rt = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_wen", 32'(bus.wen_out), 32'd0);
        check("rst_aluop", 32'(bus.aluop), 32'd0);
        check("rst_a", bus.a, 32'd0);
        check("rst_b", bus.b, 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_dest", 32'(bus.dest), 32'd0);
        check("rst_isload", 32'(bus.is_load_out), 32'd0);

        // First instruction after reset
        rst = 1'b0;
        set_id(1'b1, 5'd5, 5'd6, 32'h11, 32'h66, 4'h3, 5'd7, 1'b1, 1'b0);
        tick();
        check("first_valid", 32'(bus.valid_out), 32'd1);
        check("first_aluop", 32'(bus.aluop), 32'h3);
        check("first_dest", 32'(bus.dest), 32'd7);
        check("first_wen", 32'(bus.wen_out), 32'd1);
        check("first_a", bus.a, 32'h11);
        check("first_b", bus.b, 32'h66);
        check("first_store", bus.store_data, 32'h66);

        // Forward priority on rs=5
        bus.exmem_wen = 1'b1; bus.exmem_dest = 5'd5; bus.exmem_result = 32'h22;
        bus.memwb_wen = 1'b1; bus.memwb_dest = 5'd5; bus.memwb_data   = 32'h33;
        #1;
        check("fwd_exmem_prio", bus.a, 32'h22);
        check("fwd_rt_nomatch", bus.b, 32'h66);
        bus.exmem_wen = 1'b0;
        #1;
        check("fwd_memwb", bus.a, 32'h33);

        // Register 0 never forwarded
        set_id(1'b1, 5'd0, 5'd6, 32'h11, 32'h66, 4'h1, 5'd7, 1'b1, 1'b0);
        bus.exmem_wen = 1'b1; bus.exmem_dest = 5'd0; bus.exmem_result = 32'h22;
        bus.memwb_wen = 1'b1; bus.memwb_dest = 5'd0; bus.memwb_data   = 32'h33;
        tick();
        check("fwd_r0", bus.a, 32'h11);
        clear_bypass();

        // Immediate operand
        set_id(1'b1, 5'd1, 5'd2, 32'h10, 32'h20, 4'h2, 5'd3, 1'b1, 1'b0);
        bus.id_use_imm = 1'b1;
        bus.id_imm     = 32'hFFFF_FFFC;
        tick();
        check("imm_b", bus.b, 32'hFFFF_FFFC);
        check("imm_a", bus.a, 32'h10);
        check("imm_store", bus.store_data, 32'h20);

        // Shift: A = fwd(rt), B = shamt
        set_id(1'b1, 5'd1, 5'd9, 32'h10, 32'h0, 4'h0, 5'd3, 1'b1, 1'b0);
        bus.id_is_shift = 1'b1;
        bus.id_shamt    = 5'd4;
        tick();
        bus.exmem_wen = 1'b1; bus.exmem_dest = 5'd9; bus.exmem_result = 32'h1;
        #1;
        check("shift_a", bus.a, 32'h1);
        check("shift_b", bus.b, 32'd4);
        clear_bypass();

        // Load-use hazard: load to $8 in EX
        set_id(1'b1, 5'd2, 5'd3, 32'h0, 32'h0, 4'h2, 5'd8, 1'b1, 1'b1);
        tick();
        check("load_isload", 32'(bus.is_load_out), 32'd1);
        set_id(1'b1, 5'd8, 5'd4, 32'h0, 32'h0, 4'h5, 5'd10, 1'b1, 1'b0);
        #1;
        check("lu_nouse", 32'(bus.stall), 32'd0);
        bus.id_uses_rt = 1'b1;
        bus.id_rt = 5'd8;
        #1;
        check("lu_rt", 32'(bus.stall), 32'd1);
        bus.id_uses_rt = 1'b0;
        bus.id_rt = 5'd4;
        bus.id_uses_rs = 1'b1;
        #1;
        check("lu_rs", 32'(bus.stall), 32'd1);
        tick();
        check("bubble_valid", 32'(bus.valid_out), 32'd0);
        check("bubble_wen", 32'(bus.wen_out), 32'd0);
        check("bubble_dest", 32'(bus.dest), 32'd0);
        check("bubble_stall", 32'(bus.stall), 32'd0);
        tick();
        check("after_bubble_aluop", 32'(bus.aluop), 32'h5);

        // Load to $0 never stalls
        set_id(1'b1, 5'd2, 5'd3, 32'h0, 32'h0, 4'h2, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 4'h5, 5'd10, 1'b1, 1'b0);
        bus.id_uses_rs = 1'b1;
        #1;
        check("lu_r0", 32'(bus.stall), 32'd0);

        // Hold capture of a forwarded value
        set_id(1'b1, 5'd3, 5'd4, 32'h5, 32'h7, 4'h2, 5'd4, 1'b1, 1'b0);
        tick();
        bus.ex_en = 1'b0;
        set_id(1'b1, 5'd1, 5'd1, 32'h99, 32'h99, 4'hF, 5'd12, 1'b0, 1'b0);
        bus.memwb_wen = 1'b1; bus.memwb_dest = 5'd3; bus.memwb_data = 32'hABCD;
        #1;
        check("hold_fwd", bus.a, 32'hABCD);
        tick();
        bus.memwb_wen = 1'b0;
        #1;
        check("hold_kept", bus.a, 32'hABCD);
        check("hold_aluop", 32'(bus.aluop), 32'h2);
        check("hold_dest", 32'(bus.dest), 32'd4);
        tick();
        check("hold2_a", bus.a, 32'hABCD);
        check("hold2_valid", 32'(bus.valid_out), 32'd1);
        check("hold2_wen", 32'(bus.wen_out), 32'd1);

        // Flush while held: contents unchanged
        bus.flush = 1'b1;
        tick();
        check("flush_held_valid", 32'(bus.valid_out), 32'd1);
        check("flush_held_aluop", 32'(bus.aluop), 32'h2);

        // Flush with advance: bubble
        bus.ex_en = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 4'h7, 5'd9, 1'b1, 1'b0);
        tick();
        check("flush_valid", 32'(bus.valid_out), 32'd0);
        check("flush_wen", 32'(bus.wen_out), 32'd0);

        // Normal flow resumes
        bus.flush = 1'b0;
        tick();
        check("resume_aluop", 32'(bus.aluop), 32'h7);
        check("resume_b", bus.b, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
